fmap_stream_reader: RTL and testbench

- Reader half of the layer's RAM interface: scans one stored feature map and streams 4-lane pixels toward the layer's `inA` path and conv input buffers.
- Source RAM: row-major, one address per pixel, 4x16-bit lanes per word, 1-cycle read latency.
- Inserts zero-padding border pixels without RAM access and tags them so the controller can drive the input buffer's zero-input control.
- Output side is a valid/ready stream with row markers and a Done pulse, so the layer controller can stall the scan at any element.

---
 rtl/fmap_pkg.sv | 27 ++
 rtl/fmap_stream_reader_if.sv | 22 ++
 rtl/fmap_skid_fifo.sv | 52 +++++
 rtl/fmap_stream_reader.sv | 159 +++++++++++++++
 tb/tb_fmap_stream_reader.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fmap_pkg.sv
// Shared types for the feature-map stream reader: pixel lanes, beat tags,
// FIFO entries and the scan state encoding.
package fmap_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned LANES  = 4;

    typedef logic [LANES-1:0][DATA_W-1:0] pixel_t;

    typedef struct packed {
        logic zero;
        logic row_start;
        logic last;
    } tag_t;

    typedef struct packed {
        pixel_t data;
        tag_t   tag;
    } fifo_entry_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } rd_state_t;

endpackage

// File: rtl/fmap_stream_reader_if.sv
// Output pixel stream of the feature-map reader: lanes, flags and valid/ready.
interface fmap_stream_reader_if;
    import fmap_pkg::*;

    pixel_t Out_Data;
    logic   Out_Valid;
    logic   Out_Ready;
    logic   Out_Zero;
    logic   Out_Row_Start;
    logic   Out_Last;

    modport master (
        output Out_Data, Out_Valid, Out_Zero, Out_Row_Start, Out_Last,
        input  Out_Ready
    );

    modport slave (
        input  Out_Data, Out_Valid, Out_Zero, Out_Row_Start, Out_Last,
        output Out_Ready
    );

endinterface

// File: rtl/fmap_skid_fifo.sv
// Two-entry FIFO of tagged pixel beats; head is read straight from storage so it
// holds still while the consumer stalls.
module fmap_skid_fifo
    import fmap_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  fifo_entry_t in_entry,
    output logic        out_valid,
    input  logic        out_ready,
    output fifo_entry_t out_entry,
    output logic [1:0]  count
);

    fifo_entry_t mem [2];
    logic        wr_ptr;
    logic        rd_ptr;
    logic        push;
    logic        pop;

    assign out_valid = (count != 2'd0);
    assign in_ready  = (count != 2'd2) || out_ready;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_entry = out_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_entry;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fmap_stream_reader.sv
// Scans a row-major feature map from RAM, inserts an optional zero border and
// streams tagged 4-lane beats. FMAP_STALL_CNT_EN adds the Stall_Count output.
module fmap_stream_reader
    import fmap_pkg::*;
#(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DIM_W  = 7
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 Start,
    input  logic [ADDR_W-1:0]    Base_Addr,
    input  logic [DIM_W-1:0]     Width,
    input  logic [DIM_W-1:0]     Height,
    input  logic                 Pad,
    output logic                 RAM_Rd_En,
    output logic [ADDR_W-1:0]    RAM_Addr,
    input  pixel_t               RAM_Rd_Data,
    fmap_stream_reader_if.master stream,
    output logic                 Busy,
`ifdef FMAP_STALL_CNT_EN
    output logic                 Done,
    output logic [15:0]          Stall_Count
`else
    output logic                 Done
`endif
);

    typedef logic [DIM_W:0] pdim_t;

    rd_state_t         state;
    pdim_t             pw_m1;
    pdim_t             ph_m1;
    pdim_t             row;
    pdim_t             col;
    logic              pad_q;
    logic [ADDR_W-1:0] rd_ptr;
    logic              stg_valid;
    tag_t              stg_tag;
    tag_t              pos_tag;
    fifo_entry_t       stg_entry;
    fifo_entry_t       head;
    logic              head_valid;
    logic              fifo_in_ready;
    logic [1:0]        fifo_count;
    logic [2:0]        occupancy;
    logic              issue;
    logic              pop;

    always_comb begin
        pos_tag.zero      = pad_q && (row == '0 || row == ph_m1 || col == '0 || col == pw_m1);
        pos_tag.row_start = (col == '0);
        pos_tag.last      = (row == ph_m1) && (col == pw_m1);
    end

    // A beat leaving this cycle frees its slot, so the gate keeps
    // occupancy + in-flight <= 2 while still allowing one beat per cycle.
    assign occupancy = {1'b0, fifo_count} + {2'b00, stg_valid};
    assign pop       = head_valid && stream.Out_Ready;
    assign issue     = (state == ISSUE) && ((occupancy < 3'd2) || pop);

    assign RAM_Rd_En = issue && !pos_tag.zero;
    assign RAM_Addr  = rd_ptr;
    assign Busy      = (state != IDLE);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= IDLE;
            pw_m1     <= '0;
            ph_m1     <= '0;
            pad_q     <= 1'b0;
            row       <= '0;
            col       <= '0;
            rd_ptr    <= '0;
            stg_valid <= 1'b0;
            stg_tag   <= '0;
            Done      <= 1'b0;
        end else begin
            Done      <= 1'b0;
            stg_valid <= issue;
            if (issue) begin
                stg_tag <= pos_tag;
            end
            if (issue && !pos_tag.zero) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            case (state)
                IDLE: begin
                    if (Start) begin
                        pw_m1  <= {1'b0, Width}  + {{(DIM_W-1){1'b0}}, Pad, 1'b0} - pdim_t'(1);
                        ph_m1  <= {1'b0, Height} + {{(DIM_W-1){1'b0}}, Pad, 1'b0} - pdim_t'(1);
                        pad_q  <= Pad;
                        rd_ptr <= Base_Addr;
                        row    <= '0;
                        col    <= '0;
                        state  <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (issue) begin
                        if (pos_tag.last) begin
                            state <= DRAIN;
                        end else if (col == pw_m1) begin
                            col <= '0;
                            row <= row + pdim_t'(1);
                        end else begin
                            col <= col + pdim_t'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (pop && head.tag.last) begin
                        state <= IDLE;
                        Done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        stg_entry.data = stg_tag.zero ? '0 : RAM_Rd_Data;
        stg_entry.tag  = stg_tag;
    end

    fmap_skid_fifo u_fifo (
        .clk       (CLK),
        .rst_n     (RST_N),
        .in_valid  (stg_valid),
        .in_ready  (fifo_in_ready),
        .in_entry  (stg_entry),
        .out_valid (head_valid),
        .out_ready (stream.Out_Ready),
        .out_entry (head),
        .count     (fifo_count)
    );

    assign stream.Out_Valid     = head_valid;
    assign stream.Out_Data      = head.data;
    assign stream.Out_Zero      = head.tag.zero;
    assign stream.Out_Row_Start = head.tag.row_start;
    assign stream.Out_Last      = head.tag.last;

    stage_never_blocked: assert property (@(posedge CLK) disable iff (!RST_N) stg_valid |-> fifo_in_ready);

`ifdef FMAP_STALL_CNT_EN
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            Stall_Count <= '0;
        end else if (state == IDLE && Start) begin
            Stall_Count <= '0;
        end else if (head_valid && !stream.Out_Ready && Stall_Count != 16'hFFFF) begin
            Stall_Count <= Stall_Count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fmap_stream_reader.sv
// Directed bench for fmap_stream_reader: hand-tabulated beat/read sequences,
// backpressure, repeated Start, and mid-scan asynchronous reset.
`timescale 1ns/1ps
module tb_fmap_stream_reader;
    import fmap_pkg::*;

    typedef struct packed {
        logic   zero;
        logic   row_start;
        logic   last;
        pixel_t data;
    } beat_t;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        Start = 1'b0;
    logic [11:0] Base_Addr = '0;
    logic [6:0]  Width = '0;
    logic [6:0]  Height = '0;
    logic        Pad = 1'b0;
    logic        RAM_Rd_En;
    logic [11:0] RAM_Addr;
    pixel_t      RAM_Rd_Data = '0;
    logic        Busy;
    logic        Done;
`ifdef FMAP_STALL_CNT_EN
    logic [15:0] Stall_Count;
`endif

    fmap_stream_reader_if stream ();

    fmap_stream_reader #(.ADDR_W(12), .DIM_W(7)) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .Start       (Start),
        .Base_Addr   (Base_Addr),
        .Width       (Width),
        .Height      (Height),
        .Pad         (Pad),
        .RAM_Rd_En   (RAM_Rd_En),
        .RAM_Addr    (RAM_Addr),
        .RAM_Rd_Data (RAM_Rd_Data),
        .stream      (stream),
        .Busy        (Busy),
`ifdef FMAP_STALL_CNT_EN
        .Done        (Done),
        .Stall_Count (Stall_Count)
`else
        .Done        (Done)
`endif
    );

    always #5 CLK = ~CLK;

    function automatic pixel_t ram_word(input logic [11:0] a);
        pixel_t w;
        w[0] = {4'hA, a};
        w[1] = {4'hB, a};
        w[2] = {4'hC, a};
        w[3] = {4'hD, a};
        return w;
    endfunction

    always @(posedge CLK) begin
        if (RAM_Rd_En) RAM_Rd_Data <= ram_word(RAM_Addr);
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check_vec(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, got, exp);
        end
    endtask

    int          cyc = 0;
    beat_t       beats[$];
    int          acc_cyc[$];
    logic [11:0] reads[$];
    int          read_cyc[$];
    int          first_valid_cyc = -1;
    int          done_cyc = -1;
    int          done_cnt = 0;
    int          stall_cycles = 0;
    int          start_cyc = 0;
    bit          hold_pending = 0;
    beat_t       held;
    bit          ready_pat = 0;
    int          ph = 0;
    beat_t       exp_q[$];
    logic [11:0] exp_rd[$];

    always @(posedge CLK) cyc <= cyc + 1;

    // Out_Ready is set for the coming edge, then outputs are sampled mid-cycle.
    always @(negedge CLK) begin
        beat_t cur;
        stream.Out_Ready = ready_pat ? ((ph % 4) == 0 || (ph % 4) == 3) : 1'b1;
        ph++;
        #1;
        cur.zero      = stream.Out_Zero;
        cur.row_start = stream.Out_Row_Start;
        cur.last      = stream.Out_Last;
        cur.data      = stream.Out_Data;
        if (RST_N) begin
            if (hold_pending) check_vec("stall hold", {stream.Out_Valid, cur}, {1'b1, held});
            hold_pending = 0;
            if (stream.Out_Valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (stream.Out_Valid && stream.Out_Ready) begin
                beats.push_back(cur);
                acc_cyc.push_back(cyc);
            end else if (stream.Out_Valid) begin
                hold_pending = 1;
                held = cur;
                stall_cycles++;
            end
            if (RAM_Rd_En) begin
                reads.push_back(RAM_Addr);
                read_cyc.push_back(cyc);
            end
            if (Done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic clear_obs();
        beats.delete();
        acc_cyc.delete();
        reads.delete();
        read_cyc.delete();
        first_valid_cyc = -1;
        done_cyc = -1;
        done_cnt = 0;
        stall_cycles = 0;
        hold_pending = 0;
    endtask

    task automatic add_beat(input logic z, input logic rs, input logic last, input logic [11:0] a);
        beat_t b;
        b.zero      = z;
        b.row_start = rs;
        b.last      = last;
        b.data      = z ? '0 : ram_word(a);
        exp_q.push_back(b);
    endtask

    // 3x2, no pad: rows start on beats 0 and 3, last on beat 5.
    task automatic build_s1(input logic [11:0] base);
        exp_q.delete();
        exp_rd.delete();
        for (int i = 0; i < 6; i++) begin
            add_beat(1'b0, (i == 0 || i == 3), (i == 5), base + 12'(i));
            exp_rd.push_back(base + 12'(i));
        end
    endtask

    // 3x2 padded to 5x4: word index per beat, -1 for border.
    task automatic build_s2(input logic [11:0] base);
        int idx [20] = '{-1, -1, -1, -1, -1, -1, 0, 1, 2, -1, -1, 3, 4, 5, -1, -1, -1, -1, -1, -1};
        exp_q.delete();
        exp_rd.delete();
        for (int i = 0; i < 20; i++) begin
            add_beat(idx[i] < 0, (i % 5) == 0, i == 19, base + 12'(idx[i]));
        end
        for (int i = 0; i < 6; i++) exp_rd.push_back(base + 12'(i));
    endtask

    task automatic start_scan(input logic [11:0] b, input logic [6:0] w, input logic [6:0] h,
                              input logic p, input bit pat);
        clear_obs();
        ready_pat = pat;
        ph = 0;
        @(negedge CLK);
        Base_Addr = b;
        Width = w;
        Height = h;
        Pad = p;
        Start = 1'b1;
        start_cyc = cyc;
        @(negedge CLK);
        Start = 1'b0;
        check_vec("busy after start", Busy, 1);
    endtask

    task automatic wait_done(input string nm);
        int i = 0;
        while (done_cnt == 0 && i < 400) begin
            @(negedge CLK);
            #2;
            i++;
        end
        check_vec({nm, " done seen"}, done_cnt, 1);
        repeat (3) @(negedge CLK);
        #2;
        check_vec({nm, " done pulses"}, done_cnt, 1);
        check_vec({nm, " busy idle"}, Busy, 0);
        if (acc_cyc.size() > 0) check_vec({nm, " done timing"}, done_cyc - acc_cyc[acc_cyc.size()-1], 1);
    endtask

    task automatic compare_scan(input string nm);
        check_vec({nm, " beats"}, beats.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < beats.size(); i++)
            check_vec($sformatf("%s b%0d", nm, i), beats[i], exp_q[i]);
        check_vec({nm, " reads"}, reads.size(), exp_rd.size());
        for (int i = 0; i < exp_rd.size() && i < reads.size(); i++)
            check_vec($sformatf("%s rd%0d", nm, i), reads[i], exp_rd[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge CLK);
        #1;
        check_vec("reset outputs",
                  {RAM_Rd_En, RAM_Addr, stream.Out_Data, stream.Out_Valid, stream.Out_Zero,
                   stream.Out_Row_Start, stream.Out_Last, Busy, Done}, '0);
`ifdef FMAP_STALL_CNT_EN
        check_vec("reset stall count", Stall_Count, 0);
`endif
        @(negedge CLK);
        RST_N = 1'b1;

        // S1: 3x2 no pad, full throughput
        build_s1(12'h010);
        start_scan(12'h010, 7'd3, 7'd2, 1'b0, 0);
        wait_done("s1");
        compare_scan("s1");
        check_vec("s1 latency", first_valid_cyc - (start_cyc + 1), 2);
        if (acc_cyc.size() == 6) check_vec("s1 beat span", acc_cyc[5] - acc_cyc[0], 5);
        if (read_cyc.size() == 6) check_vec("s1 read span", read_cyc[5] - read_cyc[0], 5);

        // S2: 3x2 padded
        build_s2(12'h020);
        start_scan(12'h020, 7'd3, 7'd2, 1'b1, 0);
        wait_done("s2");
        compare_scan("s2");

        // S3: S1 config under 1,0,0,1 backpressure
        build_s1(12'h010);
        start_scan(12'h010, 7'd3, 7'd2, 1'b0, 1);
        wait_done("s3");
        compare_scan("s3");
        check_vec("s3 stalls seen", stall_cycles != 0, 1);
`ifdef FMAP_STALL_CNT_EN
        check_vec("s3 stall count", Stall_Count, stall_cycles);
`endif

        // S4: single pixel at top of address space
        exp_q.delete();
        exp_rd.delete();
        add_beat(1'b0, 1'b1, 1'b1, 12'hFFF);
        exp_rd.push_back(12'hFFF);
        start_scan(12'hFFF, 7'd1, 7'd1, 1'b0, 0);
        wait_done("s4");
        compare_scan("s4");

        // S5: second Start mid-scan with a different config is ignored
        build_s1(12'h010);
        start_scan(12'h010, 7'd3, 7'd2, 1'b0, 0);
        for (int g = 0; g < 100 && beats.size() < 2; g++) begin
            @(negedge CLK);
            #2;
        end
        @(negedge CLK);
        Base_Addr = 12'h200;
        Width = 7'd5;
        Height = 7'd4;
        Pad = 1'b1;
        Start = 1'b1;
        check_vec("s5 busy at restart", Busy, 1);
        @(negedge CLK);
        Start = 1'b0;
        wait_done("s5");
        compare_scan("s5");

        // S6: asynchronous reset mid padded scan, then clean rerun
        build_s2(12'h020);
        start_scan(12'h020, 7'd3, 7'd2, 1'b1, 0);
        for (int g = 0; g < 100 && beats.size() < 4; g++) begin
            @(negedge CLK);
            #2;
        end
        check_vec("s6 reached beat 4", beats.size() >= 4, 1);
        RST_N = 1'b0;
        #1;
        check_vec("s6 async reset outputs",
                  {RAM_Rd_En, RAM_Addr, stream.Out_Data, stream.Out_Valid, stream.Out_Zero,
                   stream.Out_Row_Start, stream.Out_Last, Busy, Done}, '0);
        repeat (3) @(negedge CLK);
        check_vec("s6 no done on reset", done_cnt, 0);
        RST_N = 1'b1;
        start_scan(12'h020, 7'd3, 7'd2, 1'b1, 0);
        wait_done("s6");
        compare_scan("s6");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
